// File: rtl/puzzle_pkg.sv
// Shared definitions for the arithmetic puzzle: key codes, FSM states and ALU opcodes.
package puzzle_pkg;

   localparam logic [3:0] KEY_ADD    = 4'hA;
   localparam logic [3:0] KEY_SUB    = 4'hB;
   localparam logic [3:0] KEY_DIV    = 4'hC;
   localparam logic [3:0] KEY_MUL    = 4'hD;
   localparam logic [3:0] KEY_UNDO   = 4'hE;
   localparam logic [3:0] KEY_CANCEL = 4'hF;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SEL1  = 3'd1,
      ST_SEL2  = 3'd2,
      ST_SELOP = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_SUB = 2'd1,
      OP_DIV = 2'd2,
      OP_MUL = 2'd3
   } op_e;

   function automatic logic key_is_op(input logic [3:0] k);
      return (k >= KEY_ADD) && (k <= KEY_MUL);
   endfunction

   function automatic op_e key_to_op(input logic [3:0] k);
      case (k)
         KEY_SUB: return OP_SUB;
         KEY_DIV: return OP_DIV;
         KEY_MUL: return OP_MUL;
         default: return OP_ADD;
      endcase
   endfunction

endpackage

// File: rtl/arith_puzzle_fsm_if.sv
// Player-side bus of the puzzle: load/restart/key inputs and the registered game view.
interface arith_puzzle_fsm_if #(
   parameter int N_NUM = 4,
   parameter int W     = 10
) ();
   localparam int CW = $clog2(N_NUM + 1);

   logic                 load;
   logic [N_NUM*W-1:0]   load_vals;
   logic                 restart;
   logic                 key_valid;
   logic [3:0]           key_code;
   logic [N_NUM*W-1:0]   nums_out;
   logic [CW-1:0]        how_many;
   logic [2:0]           sel_a;
   logic [2:0]           sel_b;
   logic [1:0]           sel_valid;
   logic                 win;
   logic                 lose;
   logic                 err;

   modport master (
      output load, load_vals, restart, key_valid, key_code,
      input  nums_out, how_many, sel_a, sel_b, sel_valid, win, lose, err
   );

   modport slave (
      input  load, load_vals, restart, key_valid, key_code,
      output nums_out, how_many, sel_a, sel_b, sel_valid, win, lose, err
   );
endinterface

// File: rtl/puzzle_alu.sv
// Unsigned W-bit combining step for two puzzle numbers; flags results that leave the integers/range.
module puzzle_alu
   import puzzle_pkg::*;
#(
   parameter int W = 10
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  op_e          op,
   output logic [W-1:0] result,
   output logic         reject
);

   logic [2*W-1:0] w_prod;

   assign w_prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};

   always_comb begin
      result = '0;
      reject = 1'b0;
      case (op)
         OP_ADD: result = a + b;
         OP_SUB: begin
            result = a - b;
            reject = (a < b);
         end
         // Division must be exact; b == 0 is screened before the divider is used.
         OP_DIV: begin
            if (b == '0) begin
               reject = 1'b1;
            end else begin
               result = a / b;
               reject = ((a % b) != '0);
            end
         end
         OP_MUL: begin
            result = w_prod[W-1:0];
            reject = (w_prod[2*W-1:W] != '0);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/arith_puzzle_fsm.sv
// Key-driven "make TARGET" puzzle: pick two live numbers, combine them, repeat until one remains.
module arith_puzzle_fsm
   import puzzle_pkg::*;
#(
   parameter int N_NUM  = 4,
   parameter int W      = 10,
   parameter int TARGET = 24
) (
   input logic              clk,
   input logic              rst_n,
   arith_puzzle_fsm_if.slave bus
);

   localparam int CW = $clog2(N_NUM + 1);
   localparam int HD = N_NUM - 1;
   localparam int HW = (HD > 1) ? $clog2(HD) : 1;
   localparam int SW = $clog2(N_NUM);

   localparam logic [2:0] S_IDLE  = ST_IDLE;
   localparam logic [2:0] S_SEL1  = ST_SEL1;
   localparam logic [2:0] S_SEL2  = ST_SEL2;
   localparam logic [2:0] S_SELOP = ST_SELOP;
   localparam logic [2:0] S_DONE  = ST_DONE;

   logic [2:0]                  r_state;
   logic [N_NUM-1:0][W-1:0]     r_nums;
   logic [N_NUM-1:0][W-1:0]     r_orig;
   logic [N_NUM-1:0][W-1:0]     r_hist_nums [HD];
   logic [CW-1:0]               r_hist_cnt  [HD];
   logic [CW-1:0]               r_hptr;
   logic [CW-1:0]               r_cnt;
   logic [2:0]                  r_sel_a;
   logic [2:0]                  r_sel_b;
   logic [1:0]                  r_sel_v;
   logic                        r_win;
   logic                        r_lose;
   logic                        r_err;

   logic [N_NUM-1:0][W-1:0]     w_shift;
   logic [N_NUM-1:0][W-1:0]     w_next;
   logic [W-1:0]                w_a;
   logic [W-1:0]                w_b;
   logic [W-1:0]                w_res;
   logic                        w_rej;
   op_e                         w_op;
   logic [2:0]                  w_lo;
   logic [2:0]                  w_hi;
   logic [2:0]                  w_kidx;
   logic                        w_kslot;
   logic                        w_klive;
   logic                        w_cancel;
   logic                        w_undo;
   logic                        w_win;
   logic [HW-1:0]               w_push_idx;
   logic [HW-1:0]               w_pop_idx;

   // Key decode: slot keys 1..N_NUM map to slot indices 0..N_NUM-1.
   assign w_kslot  = (bus.key_code != 4'd0) && (int'(bus.key_code) <= N_NUM);
   assign w_kidx   = 3'(bus.key_code - 4'd1);
   assign w_klive  = w_kslot && (int'(w_kidx) < int'(r_cnt));
   assign w_cancel = (bus.key_code == KEY_CANCEL);
   assign w_undo   = (bus.key_code == KEY_UNDO) && (r_state != S_IDLE) && (r_hptr != '0);
   assign w_op     = key_to_op(bus.key_code);

   assign w_a = r_nums[SW'(r_sel_a)];
   assign w_b = r_nums[SW'(r_sel_b)];

   puzzle_alu #(.W(W)) u_alu (
      .a      (w_a),
      .b      (w_b),
      .op     (w_op),
      .result (w_res),
      .reject (w_rej)
   );

   assign w_lo = (r_sel_a < r_sel_b) ? r_sel_a : r_sel_b;
   assign w_hi = (r_sel_a < r_sel_b) ? r_sel_b : r_sel_a;

   for (genvar gi = 0; gi < N_NUM - 1; gi++) begin : g_shift
      assign w_shift[gi] = r_nums[gi+1];
   end
   assign w_shift[N_NUM-1] = '0;

   // Result lands in the lower selected slot; everything above the upper one slides down.
   always_comb begin
      w_next = '0;
      for (int i = 0; i < N_NUM; i++) begin
         if (i == int'(w_lo))
            w_next[i] = w_res;
         else if (i < int'(w_hi))
            w_next[i] = r_nums[i];
         else
            w_next[i] = w_shift[i];
      end
   end

   assign w_win      = (w_next[0] == W'(TARGET));
   assign w_push_idx = HW'(r_hptr);
   assign w_pop_idx  = HW'(r_hptr - CW'(1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_nums  <= '0;
         r_orig  <= '0;
         r_hptr  <= '0;
         r_cnt   <= '0;
         r_sel_a <= '0;
         r_sel_b <= '0;
         r_sel_v <= '0;
         r_win   <= 1'b0;
         r_lose  <= 1'b0;
         r_err   <= 1'b0;
         for (int i = 0; i < HD; i++) begin
            r_hist_nums[i] <= '0;
            r_hist_cnt[i]  <= '0;
         end
      end else begin
         r_err <= 1'b0;
         if (bus.load) begin
            r_nums  <= bus.load_vals;
            r_orig  <= bus.load_vals;
            r_cnt   <= CW'(N_NUM);
            r_hptr  <= '0;
            r_sel_a <= '0;
            r_sel_b <= '0;
            r_sel_v <= '0;
            r_win   <= 1'b0;
            r_lose  <= 1'b0;
            r_state <= S_SEL1;
         end else if (bus.restart && (r_state != S_IDLE)) begin
            r_nums  <= r_orig;
            r_cnt   <= CW'(N_NUM);
            r_hptr  <= '0;
            r_sel_a <= '0;
            r_sel_b <= '0;
            r_sel_v <= '0;
            r_win   <= 1'b0;
            r_lose  <= 1'b0;
            r_state <= S_SEL1;
         end else if (bus.key_valid) begin
            if (w_undo) begin
               r_nums  <= r_hist_nums[w_pop_idx];
               r_cnt   <= r_hist_cnt[w_pop_idx];
               r_hptr  <= r_hptr - CW'(1);
               r_sel_a <= '0;
               r_sel_b <= '0;
               r_sel_v <= '0;
               r_win   <= 1'b0;
               r_lose  <= 1'b0;
               r_state <= S_SEL1;
            end else begin
               case (r_state)
                  S_SEL1: begin
                     if (w_klive) begin
                        r_sel_a <= w_kidx;
                        r_sel_v <= 2'b01;
                        r_state <= S_SEL2;
                     end
                  end
                  S_SEL2: begin
                     if (w_cancel) begin
                        r_sel_a <= '0;
                        r_sel_v <= '0;
                        r_state <= S_SEL1;
                     end else if (w_klive && (w_kidx != r_sel_a)) begin
                        r_sel_b <= w_kidx;
                        r_sel_v <= 2'b11;
                        r_state <= S_SELOP;
                     end
                  end
                  S_SELOP: begin
                     if (w_cancel) begin
                        r_sel_a <= '0;
                        r_sel_b <= '0;
                        r_sel_v <= '0;
                        r_state <= S_SEL1;
                     end else if (key_is_op(bus.key_code)) begin
                        r_sel_a <= '0;
                        r_sel_b <= '0;
                        r_sel_v <= '0;
                        if (w_rej) begin
                           r_err   <= 1'b1;
                           r_state <= S_SEL1;
                        end else begin
                           r_hist_nums[w_push_idx] <= r_nums;
                           r_hist_cnt[w_push_idx]  <= r_cnt;
                           r_hptr  <= r_hptr + CW'(1);
                           r_nums  <= w_next;
                           r_cnt   <= r_cnt - CW'(1);
                           if (r_cnt == CW'(2)) begin
                              r_win   <= w_win;
                              r_lose  <= !w_win;
                              r_state <= S_DONE;
                           end else begin
                              r_state <= S_SEL1;
                           end
                        end
                     end
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   assign bus.nums_out  = r_nums;
   assign bus.how_many  = r_cnt;
   assign bus.sel_a     = r_sel_a;
   assign bus.sel_b     = r_sel_b;
   assign bus.sel_valid = r_sel_v;
   assign bus.win       = r_win;
   assign bus.lose      = r_lose;
   assign bus.err       = r_err;

endmodule

// File: tb/tb_arith_puzzle_fsm.sv
// Bench for arith_puzzle_fsm: scripted vector table, then random keys against a list-based game model.
module tb_arith_puzzle_fsm;

   localparam int N    = 4;
   localparam int W    = 10;
   localparam int TGT  = 24;
   localparam int CW   = $clog2(N + 1);
   localparam int MAXV = 1 << W;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   arith_puzzle_fsm_if #(.N_NUM(N), .W(W)) bus ();

   arith_puzzle_fsm #(.N_NUM(N), .W(W), .TARGET(TGT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // ---------------- behavioural model: live numbers kept as a list ----------------
   typedef struct {
      int v [N];
      int cnt;
   } snap_t;

   int    m_live [$];
   int    m_orig [$];
   snap_t m_hist [$];
   int    m_st;        // 0 idle, 1 pick first, 2 pick second, 3 pick operator, 4 game over
   int    m_sa, m_sb;
   int    m_sv;
   bit    m_win, m_lose, m_err;

   function automatic void m_clr();
      m_sa = 0; m_sb = 0; m_sv = 0;
   endfunction

   task automatic m_step(input bit rst, input bit ld, input logic [N*W-1:0] vals,
                         input bit rs, input bit kv, input logic [3:0] kc);
      int a, b, r, lo, hi, k;
      bit rej;
      snap_t s;
      m_err = 0;
      k = int'(kc);
      if (!rst) begin
         m_live.delete(); m_orig.delete(); m_hist.delete();
         m_st = 0; m_clr(); m_win = 0; m_lose = 0;
      end else if (ld) begin
         m_live.delete();
         for (int i = 0; i < N; i++) m_live.push_back(int'(vals[i*W +: W]));
         m_orig = m_live;
         m_hist.delete(); m_clr(); m_win = 0; m_lose = 0; m_st = 1;
      end else if (rs && m_st != 0) begin
         m_live = m_orig;
         m_hist.delete(); m_clr(); m_win = 0; m_lose = 0; m_st = 1;
      end else if (kv && m_st != 0) begin
         if (k == 14) begin
            if (m_hist.size() > 0) begin
               s = m_hist.pop_back();
               m_live.delete();
               for (int i = 0; i < s.cnt; i++) m_live.push_back(s.v[i]);
               m_clr(); m_win = 0; m_lose = 0; m_st = 1;
            end
         end else if (m_st == 1) begin
            if (k >= 1 && k <= m_live.size()) begin
               m_sa = k - 1; m_sv = 1; m_st = 2;
            end
         end else if (m_st == 2) begin
            if (k == 15) begin
               m_clr(); m_st = 1;
            end else if (k >= 1 && k <= m_live.size() && k - 1 != m_sa) begin
               m_sb = k - 1; m_sv = 3; m_st = 3;
            end
         end else if (m_st == 3) begin
            if (k == 15) begin
               m_clr(); m_st = 1;
            end else if (k >= 10 && k <= 13) begin
               a = m_live[m_sa]; b = m_live[m_sb];
               lo = (m_sa < m_sb) ? m_sa : m_sb;
               hi = (m_sa < m_sb) ? m_sb : m_sa;
               rej = 0; r = 0;
               case (k)
                  10: r = (a + b) % MAXV;
                  11: begin rej = (a < b); r = a - b; end
                  12: begin
                     if (b == 0) rej = 1;
                     else begin rej = ((a % b) != 0); r = a / b; end
                  end
                  default: begin rej = (a * b >= MAXV); r = a * b; end
               endcase
               m_clr();
               if (rej) begin
                  m_err = 1; m_st = 1;
               end else begin
                  s.cnt = m_live.size();
                  for (int i = 0; i < N; i++) s.v[i] = (i < m_live.size()) ? m_live[i] : 0;
                  m_hist.push_back(s);
                  m_live[lo] = r;
                  m_live.delete(hi);
                  if (m_live.size() == 1) begin
                     m_st = 4; m_win = (m_live[0] == TGT); m_lose = !m_win;
                  end else begin
                     m_st = 1;
                  end
               end
            end
         end
      end
   endtask

   task automatic chk_model(input string tag);
      logic [N*W-1:0] en;
      en = '0;
      for (int i = 0; i < m_live.size(); i++) en[i*W +: W] = W'(m_live[i]);
      n_tests++;
      if (bus.nums_out !== en || bus.how_many !== CW'(m_live.size()) ||
          bus.sel_a !== 3'(m_sa) || bus.sel_b !== 3'(m_sb) || bus.sel_valid !== 2'(m_sv) ||
          bus.win !== m_win || bus.lose !== m_lose || bus.err !== m_err) begin
         n_fail++;
         $display("FAIL model %s: got nums=%h cnt=%0d sa=%0d sb=%0d sv=%b w=%b l=%b e=%b, want nums=%h cnt=%0d sa=%0d sb=%0d sv=%0d w=%b l=%b e=%b",
                  tag, bus.nums_out, bus.how_many, bus.sel_a, bus.sel_b, bus.sel_valid,
                  bus.win, bus.lose, bus.err, en, m_live.size(), m_sa, m_sb, m_sv,
                  m_win, m_lose, m_err);
      end
   endtask

   // One clock: drive, let the edge happen, sample 1 time unit later, check model.
   task automatic step(input bit rst, input bit ld, input logic [N*W-1:0] vals,
                       input bit rs, input bit kv, input logic [3:0] kc, input string tag);
      rst_n         = rst;
      bus.load      = ld;
      bus.load_vals = vals;
      bus.restart   = rs;
      bus.key_valid = kv;
      bus.key_code  = kc;
      @(posedge clk);
      #1;
      m_step(rst, ld, vals, rs, kv, kc);
      chk_model(tag);
   endtask

   // ---------------- scripted vectors ----------------
   typedef struct {
      bit             rst;
      bit             ld;
      logic [N*W-1:0] vals;
      bit             rs;
      bit             kv;
      logic [3:0]     kc;
      logic [N*W-1:0] e_nums;
      int             e_cnt;
      logic [1:0]     e_sv;
      bit             e_win;
      bit             e_lose;
      bit             e_err;
   } vec_t;

   vec_t tbl [$];

   function automatic logic [N*W-1:0] pk(input int a, input int b, input int c, input int d);
      return {W'(d), W'(c), W'(b), W'(a)};
   endfunction

   function automatic void T(input bit rst, input bit ld, input logic [N*W-1:0] vals,
                             input bit rs, input bit kv, input logic [3:0] kc,
                             input logic [N*W-1:0] en, input int ec, input logic [1:0] esv,
                             input bit ew, input bit el, input bit ee);
      vec_t v;
      v.rst = rst; v.ld = ld; v.vals = vals; v.rs = rs; v.kv = kv; v.kc = kc;
      v.e_nums = en; v.e_cnt = ec; v.e_sv = esv; v.e_win = ew; v.e_lose = el; v.e_err = ee;
      tbl.push_back(v);
   endfunction

   function automatic void K(input logic [3:0] kc, input logic [N*W-1:0] en,
                             input int ec, input logic [1:0] esv);
      T(1, 0, '0, 0, 1, kc, en, ec, esv, 0, 0, 0);
   endfunction

   function automatic void L(input logic [N*W-1:0] vals);
      T(1, 1, vals, 0, 0, 4'd0, vals, 4, 2'b00, 0, 0, 0);
   endfunction

   initial begin
      logic [N*W-1:0] p0, p1, p2, p3;
      bus.load = 0; bus.load_vals = '0; bus.restart = 0; bus.key_valid = 0; bus.key_code = '0;

      T(0, 0, '0, 0, 0, 4'd0, '0, 0, 2'b00, 0, 0, 0);
      // win path, undo chain, restart in SEL2, then win again
      p0 = pk(4, 7, 8, 8); p1 = pk(4, 7, 1, 0); p2 = pk(4, 6, 0, 0); p3 = pk(24, 0, 0, 0);
      L(p0);
      K(4'd3, p0, 4, 2'b01); K(4'd4, p0, 4, 2'b11); K(4'hC, p1, 3, 2'b00);
      K(4'd2, p1, 3, 2'b01); K(4'd3, p1, 3, 2'b11); K(4'hB, p2, 2, 2'b00);
      K(4'hE, p1, 3, 2'b00); K(4'hE, p0, 4, 2'b00); K(4'hE, p0, 4, 2'b00);
      K(4'd1, p0, 4, 2'b01);
      T(1, 0, '0, 1, 0, 4'd0, p0, 4, 2'b00, 0, 0, 0);
      K(4'd3, p0, 4, 2'b01); K(4'd4, p0, 4, 2'b11); K(4'hC, p1, 3, 2'b00);
      K(4'd2, p1, 3, 2'b01); K(4'd3, p1, 3, 2'b11); K(4'hB, p2, 2, 2'b00);
      K(4'd1, p2, 2, 2'b01); K(4'd2, p2, 2, 2'b11);
      T(1, 0, '0, 0, 1, 4'hD, p3, 1, 2'b00, 1, 0, 0);
      T(1, 0, '0, 0, 1, 4'd1, p3, 1, 2'b00, 1, 0, 0);
      K(4'hE, p2, 2, 2'b00);
      // rejections and a legal multiply
      p0 = pk(5, 0, 3, 2); p1 = pk(15, 0, 2, 0);
      L(p0);
      K(4'd1, p0, 4, 2'b01); K(4'd2, p0, 4, 2'b11);
      T(1, 0, '0, 0, 1, 4'hC, p0, 4, 2'b00, 0, 0, 1);
      T(1, 0, '0, 0, 0, 4'd0, p0, 4, 2'b00, 0, 0, 0);
      K(4'd3, p0, 4, 2'b01); K(4'd1, p0, 4, 2'b11);
      T(1, 0, '0, 0, 1, 4'hB, p0, 4, 2'b00, 0, 0, 1);
      K(4'd1, p0, 4, 2'b01); K(4'd3, p0, 4, 2'b11); K(4'hD, p1, 3, 2'b00);
      K(4'd1, p1, 3, 2'b01); K(4'd1, p1, 3, 2'b01); K(4'd4, p1, 3, 2'b01);
      K(4'hF, p1, 3, 2'b00); K(4'hF, p1, 3, 2'b00);
      // multiply at the edge of the W-bit range
      p0 = pk(32, 32, 31, 33); p1 = pk(32, 32, 1023, 0);
      L(p0);
      K(4'd1, p0, 4, 2'b01); K(4'd2, p0, 4, 2'b11);
      T(1, 0, '0, 0, 1, 4'hD, p0, 4, 2'b00, 0, 0, 1);
      K(4'd3, p0, 4, 2'b01); K(4'd4, p0, 4, 2'b11); K(4'hD, p1, 3, 2'b00);
      // lose then undo
      p0 = pk(1, 1, 1, 1); p1 = pk(2, 1, 1, 0); p2 = pk(3, 1, 0, 0); p3 = pk(4, 0, 0, 0);
      L(p0);
      K(4'd1, p0, 4, 2'b01); K(4'd2, p0, 4, 2'b11); K(4'hA, p1, 3, 2'b00);
      K(4'd1, p1, 3, 2'b01); K(4'd2, p1, 3, 2'b11); K(4'hA, p2, 2, 2'b00);
      K(4'd1, p2, 2, 2'b01); K(4'd2, p2, 2, 2'b11);
      T(1, 0, '0, 0, 1, 4'hA, p3, 1, 2'b00, 0, 1, 0);
      K(4'hE, p2, 2, 2'b00);
      // priority: load beats key, reset mid-operation, restart ignored when idle
      p0 = pk(9, 9, 9, 9); p1 = pk(2, 3, 4, 5);
      T(1, 1, p0, 0, 1, 4'd1, p0, 4, 2'b00, 0, 0, 0);
      K(4'd1, p0, 4, 2'b01); K(4'd2, p0, 4, 2'b11);
      T(0, 0, '0, 0, 1, 4'hA, '0, 0, 2'b00, 0, 0, 0);
      K(4'hA, '0, 0, 2'b00);
      T(1, 0, '0, 1, 0, 4'd0, '0, 0, 2'b00, 0, 0, 0);
      L(p1);
      T(1, 0, '0, 1, 1, 4'd1, p1, 4, 2'b00, 0, 0, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].rst, tbl[i].ld, tbl[i].vals, tbl[i].rs, tbl[i].kv, tbl[i].kc, "vec");
         n_tests++;
         if (bus.nums_out !== tbl[i].e_nums || bus.how_many !== CW'(tbl[i].e_cnt) ||
             bus.sel_valid !== tbl[i].e_sv || bus.win !== tbl[i].e_win ||
             bus.lose !== tbl[i].e_lose || bus.err !== tbl[i].e_err) begin
            n_fail++;
            $display("FAIL vec%0d: got nums=%h cnt=%0d sv=%b w=%b l=%b e=%b, want nums=%h cnt=%0d sv=%b w=%b l=%b e=%b",
                     i, bus.nums_out, bus.how_many, bus.sel_valid, bus.win, bus.lose, bus.err,
                     tbl[i].e_nums, tbl[i].e_cnt, tbl[i].e_sv, tbl[i].e_win, tbl[i].e_lose,
                     tbl[i].e_err);
         end
      end

      // ---------------- random play against the model ----------------
      step(0, 0, '0, 0, 0, 4'd0, "rnd_rst");
      for (int c = 0; c < 4000; c++) begin
         int r;
         bit rst, ld, rs, kv;
         logic [3:0] kc;
         logic [N*W-1:0] vals;
         r   = int'($urandom_range(0, 99));
         rst = !(r < 1);
         ld  = (r >= 1) && (r < 5);
         rs  = (r >= 5) && (r < 8);
         kv  = ($urandom_range(0, 9) != 0);
         kc  = 4'($urandom_range(0, 15));
         vals = '0;
         for (int i = 0; i < N; i++)
            vals[i*W +: W] = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, MAXV - 1))
                                                         : W'($urandom_range(0, 12));
         step(rst, ld, vals, rs, kv, kc, "rnd");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
